// File: rtl/cpu_pkg.sv
// Shared simple_cpu definitions: instruction width and field layout, HALT encoding, fetch FSM states.
package cpu_pkg;

   localparam int unsigned INSTR_WIDTH = 20;
   localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 20'hFFFFF;

   typedef enum logic [1:0] {
      TypeNone   = 2'b00,
      TypeAlu    = 2'b01,
      TypeLoadR  = 2'b10,
      TypeStoreR = 2'b11
   } instr_type_t;

   typedef enum logic [3:0] {
      FuncAdd = 4'd0,
      FuncSub = 4'd1
   } alu_func_t;

   // Field layout of a 20-bit instruction, MSB first.
   typedef struct packed {
      instr_type_t itype;   // [19:18]
      logic [1:0]  x1;      // [17:16]
      logic [1:0]  x2;      // [15:14]
      logic [1:0]  x3;      // [13:12]
      logic [7:0]  offset;  // [11:4]
      logic [3:0]  func;    // [3:0]
   } instr_t;

   typedef enum logic [1:0] {
      FetchIdle  = 2'b00,
      FetchFetch = 2'b01,
      FetchIssue = 2'b10,
      FetchHalt  = 2'b11
   } fetch_state_t;

endpackage

// File: rtl/instr_rom.sv
// Program memory: one synchronous write port, one synchronous read port, no reset.
module instr_rom #(
   parameter int unsigned WIDTH     = 20,
   parameter int unsigned ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program memory plus PC that issues instructions to the core over valid/ready until HALT_WORD.
module instr_fetch_unit #(
   parameter int unsigned               INSTR_WIDTH = 20,
   parameter int unsigned               PC_BITS     = 5,
   parameter logic [INSTR_WIDTH-1:0]    HALT_WORD   = 20'hFFFFF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   prog_we,
   input  logic [PC_BITS-1:0]     prog_addr,
   input  logic [INSTR_WIDTH-1:0] prog_data,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_valid,
   output logic [PC_BITS-1:0]     pc,
   output logic                   busy,
   output logic                   halted
);
   import cpu_pkg::*;

   fetch_state_t           state_q, state_d;
   logic [PC_BITS-1:0]     pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   valid_q, valid_d;
   logic                   rom_we, rom_re;
   logic [INSTR_WIDTH-1:0] fetch_buf;

   instr_rom #(
      .WIDTH     (INSTR_WIDTH),
      .ADDR_BITS (PC_BITS)
   ) u_rom (
      .clk   (clk),
      .we    (rom_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (rom_re),
      .raddr (pc_q),
      .rdata (fetch_buf)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      rom_we  = 1'b0;
      rom_re  = 1'b0;
      unique case (state_q)
         FetchIdle, FetchHalt: begin
            rom_we = prog_we;
            if (start) begin
               state_d = FetchFetch;
               pc_d    = '0;
            end
         end
         FetchFetch: begin
            rom_re  = 1'b1;
            state_d = FetchIssue;
         end
         FetchIssue: begin
            // valid low in ISSUE means the fetched word has not been examined yet
            if (!valid_q) begin
               if (fetch_buf == HALT_WORD) begin
                  state_d = FetchHalt;
               end else begin
                  instr_d = fetch_buf;
                  valid_d = 1'b1;
               end
            end else if (instr_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + 1'b1;
               state_d = FetchFetch;
            end
         end
         default: state_d = FetchIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FetchIdle;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = (state_q == FetchFetch) || (state_q == FetchIssue);
   assign halted      = (state_q == FetchHalt);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a program-order reference model.
module tb_instr_fetch_unit;

   localparam logic [19:0] HALT = 20'hFFFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        prog_we = 1'b0;
   logic [4:0]  prog_addr = '0;
   logic [19:0] prog_data = '0;
   logic        instr_ready = 1'b0;
   logic [19:0] instruction;
   logic        instr_valid;
   logic [4:0]  pc;
   logic        busy;
   logic        halted;

   int n_assert = 0;
   int n_fail   = 0;
   logic [19:0] model [32];

   instr_fetch_unit #(
      .INSTR_WIDTH (20),
      .PC_BITS     (5),
      .HALT_WORD   (20'hFFFFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] addr, input logic [19:0] data);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = data;
      model[addr] = data;
      step();
      prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n = 0;
      while (instr_valid !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk(tag, {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic wait_halted(input int budget, input string tag);
      int n = 0;
      while (halted !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk(tag, {31'd0, halted}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      step();
      step();
      chk("rst_pc", {27'd0, pc}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", {12'd0, instruction}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      rst = 1'b0;
      step();

      // basic program, latency and halt
      load(5'd0, 20'h47000);
      load(5'd1, 20'h53000);
      load(5'd2, HALT);
      instr_ready = 1'b1;
      pulse_start();
      chk("lat_busy", {31'd0, busy}, 32'd1);
      chk("lat_valid_n", {31'd0, instr_valid}, 32'd0);
      step();
      chk("lat_valid_n1", {31'd0, instr_valid}, 32'd0);
      step();
      chk("lat_valid_n2", {31'd0, instr_valid}, 32'd1);
      chk("lat_instr0", {12'd0, instruction}, 32'h47000);
      chk("lat_pc0", {27'd0, pc}, 32'd0);
      step();
      chk("hs_valid_low", {31'd0, instr_valid}, 32'd0);
      chk("hs_pc1", {27'd0, pc}, 32'd1);
      wait_valid(6, "prog_valid1");
      chk("prog_instr1", {12'd0, instruction}, 32'h53000);
      chk("prog_pc1", {27'd0, pc}, 32'd1);
      wait_halted(10, "prog_halt");
      chk("halt_pc", {27'd0, pc}, 32'd2);
      chk("halt_instr", {12'd0, instruction}, 32'h53000);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_busy", {31'd0, busy}, 32'd0);

      // backpressure, reprogramming while halted
      load(5'd0, 20'h12345);
      load(5'd1, HALT);
      instr_ready = 1'b0;
      pulse_start();
      wait_valid(6, "bp_valid");
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_hold_instr", {12'd0, instruction}, 32'h12345);
         chk("bp_hold_pc", {27'd0, pc}, 32'd0);
      end
      instr_ready = 1'b1;
      step();
      chk("bp_hs_valid", {31'd0, instr_valid}, 32'd0);
      chk("bp_hs_pc", {27'd0, pc}, 32'd1);
      wait_halted(10, "bp_halt");
      chk("bp_halt_pc", {27'd0, pc}, 32'd1);
      chk("bp_halt_instr", {12'd0, instruction}, 32'h12345);

      // PC wrap over a full memory with no HALT
      for (int i = 0; i < 32; i++) load(i[4:0], 20'h47000 ^ 20'(i));
      pulse_start();
      for (int i = 0; i < 32; i++) begin
         wait_valid(6, "wrap_valid");
         chk("wrap_pc", {27'd0, pc}, 32'(i));
         chk("wrap_instr", {12'd0, instruction}, {12'd0, model[i]});
         step();
      end
      wait_valid(6, "wrap_valid0");
      chk("wrap_pc0", {27'd0, pc}, 32'd0);
      chk("wrap_instr0", {12'd0, instruction}, 32'h47000);

      // asynchronous reset in ISSUE, no clock edge needed
      rst = 1'b1;
      #2;
      chk("arst_pc", {27'd0, pc}, 32'd0);
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_instr", {12'd0, instruction}, 32'd0);
      chk("arst_halted", {31'd0, halted}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      step();
      rst = 1'b0;

      // memory retained across reset; start/prog_we ignored while busy
      pulse_start();
      wait_valid(6, "ret_valid");
      chk("ret_instr0", {12'd0, instruction}, 32'h47000);
      step();
      start     = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 5'd1;
      prog_data = 20'hABCDE;
      step();
      start   = 1'b0;
      prog_we = 1'b0;
      wait_valid(6, "busy_valid");
      chk("busy_pc", {27'd0, pc}, 32'd1);
      chk("busy_instr", {12'd0, instruction}, {12'd0, model[1]});

      // same-cycle write and start from IDLE
      rst = 1'b1;
      step();
      rst = 1'b0;
      prog_we   = 1'b1;
      prog_addr = 5'd0;
      prog_data = 20'h72001;
      model[0]  = 20'h72001;
      start     = 1'b1;
      step();
      prog_we = 1'b0;
      start   = 1'b0;
      wait_valid(6, "same_valid");
      chk("same_instr", {12'd0, instruction}, 32'h72001);
      chk("same_pc", {27'd0, pc}, 32'd0);

      // randomized programs with random backpressure
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int r = 0; r < 4; r++) begin
         int len;
         int idx;
         int n;
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) begin
            logic [19:0] w;
            w = 20'($urandom);
            if (w == HALT) w = 20'h0;
            load(i[4:0], w);
         end
         load(5'(len), HALT);
         pulse_start();
         idx = 0;
         n   = 0;
         while (halted !== 1'b1 && n < 400) begin
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid === 1'b1 && instr_ready) begin
               chk("rnd_instr", {12'd0, instruction}, {12'd0, model[idx]});
               chk("rnd_pc", {27'd0, pc}, 32'(idx));
               idx++;
            end
            step();
            n++;
         end
         chk("rnd_halted", {31'd0, halted}, 32'd1);
         chk("rnd_count", 32'(idx), 32'(len));
         chk("rnd_halt_pc", {27'd0, pc}, 32'(len));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
